// File: rtl/button_event_unit.sv
// N-channel push-button front end: synchronise, debounce and classify each raw
// input into press / release / long-press / long-release / auto-repeat pulses.
module button_event_unit #(
  parameter int unsigned N_BTN         = 5,
  parameter int unsigned DBNC_MAX      = 20'hFFFFF,
  parameter int unsigned LONG_CNT      = 32'h0100_0000,
  parameter int unsigned REPEAT_DELAY  = 32'h0080_0000,
  parameter int unsigned REPEAT_PERIOD = 32'h0010_0000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_evt,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] long_release,
  output logic [N_BTN-1:0] repeat_evt
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = (DBNC_MAX > 0) ? $clog2(DBNC_MAX + 1) : 1;
  localparam int HW = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
  localparam int RW = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [DW-1:0] DBNC_V = DW'(DBNC_MAX);
  localparam logic [HW-1:0] LONG_V = HW'(LONG_CNT);
  localparam logic [RW-1:0] RDLY_V = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPER_V = RW'(REPEAT_PERIOD);

  typedef enum logic {
    RPT_DELAY  = 1'b0,
    RPT_PERIOD = 1'b1
  } rpt_phase_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw ^ {N_BTN{ACTIVE_LOW}};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DW-1:0] dbnc_q, dbnc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
    rpt_phase_t    phase_q, phase_d;
    logic          long_q, long_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          lp_q, lp_d;
    logic          lr_q, lr_d;
    logic          fire_q, fire_d;

    assign rpt_inc = rpt_q + RW'(1);

    // The repeat schedule free-runs while held; repeat_en only masks the output.
    always_comb begin
      dbnc_d  = dbnc_q;
      level_d = level_q;
      hold_d  = hold_q;
      rpt_d   = rpt_q;
      phase_d = phase_q;
      long_d  = long_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      lp_d    = 1'b0;
      lr_d    = 1'b0;
      fire_d  = 1'b0;

      if (sync2[i]) begin
        if (dbnc_q == DBNC_V) level_d = 1'b1;
        else                  dbnc_d  = dbnc_q + DW'(1);
      end else begin
        if (dbnc_q == '0) level_d = 1'b0;
        else              dbnc_d  = dbnc_q - DW'(1);
      end

      if (level_d && !level_q) begin
        press_d = 1'b1;
        hold_d  = '0;
        rpt_d   = '0;
        phase_d = RPT_DELAY;
      end else if (!level_d && level_q) begin
        rel_d   = 1'b1;
        lr_d    = long_q;
        long_d  = 1'b0;
        hold_d  = '0;
        rpt_d   = '0;
        phase_d = RPT_DELAY;
      end else if (level_q) begin
        if (hold_q != LONG_V) begin
          hold_d = hold_q + HW'(1);
          if (hold_d == LONG_V) begin
            lp_d   = 1'b1;
            long_d = 1'b1;
          end
        end
        if (phase_q == RPT_DELAY) begin
          if (rpt_inc == RDLY_V) begin
            fire_d  = 1'b1;
            rpt_d   = '0;
            phase_d = RPT_PERIOD;
          end else begin
            rpt_d = rpt_inc;
          end
        end else begin
          if (rpt_inc == RPER_V) begin
            fire_d = 1'b1;
            rpt_d  = '0;
          end else begin
            rpt_d = rpt_inc;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        dbnc_q  <= '0;
        hold_q  <= '0;
        rpt_q   <= '0;
        phase_q <= RPT_DELAY;
        long_q  <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lp_q    <= 1'b0;
        lr_q    <= 1'b0;
        fire_q  <= 1'b0;
      end else begin
        dbnc_q  <= dbnc_d;
        hold_q  <= hold_d;
        rpt_q   <= rpt_d;
        phase_q <= phase_d;
        long_q  <= long_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        lp_q    <= lp_d;
        lr_q    <= lr_d;
        fire_q  <= fire_d;
      end
    end

    assign level[i]        = level_q;
    assign press[i]        = press_q;
    assign release_evt[i]  = rel_q;
    assign long_press[i]   = lp_q;
    assign long_release[i] = lr_q;
    assign repeat_evt[i]   = fire_q & repeat_en[i];
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit: an active-high and an active-low
// instance see mirrored raw inputs and must produce identical events.
module tb_button_event_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] btn_raw;
  logic [1:0] btn_raw_al;
  logic [1:0] repeat_en;

  logic [1:0] level, press, release_evt, long_press, long_release, repeat_evt;
  logic [1:0] level_al, press_al, release_al, long_press_al, long_release_al, repeat_al;
  logic [11:0] obs, obs_al;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign btn_raw_al = ~btn_raw;
  assign obs    = {repeat_evt, long_release, long_press, release_evt, press, level};
  assign obs_al = {repeat_al, long_release_al, long_press_al, release_al, press_al, level_al};

  button_event_unit #(
    .N_BTN(2), .DBNC_MAX(4), .LONG_CNT(20), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .level(level), .press(press), .release_evt(release_evt), .long_press(long_press),
    .long_release(long_release), .repeat_evt(repeat_evt)
  );

  button_event_unit #(
    .N_BTN(2), .DBNC_MAX(4), .LONG_CNT(20), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw_al), .repeat_en(repeat_en),
    .level(level_al), .press(press_al), .release_evt(release_al), .long_press(long_press_al),
    .long_release(long_release_al), .repeat_evt(repeat_al)
  );

  function automatic logic [11:0] ev(input int ch, input bit lvl, input bit prs, input bit rel,
                                     input bit lp, input bit lr, input bit rpt);
    logic [11:0] v;
    v = {1'b0, rpt, 1'b0, lr, 1'b0, lp, 1'b0, rel, 1'b0, prs, 1'b0, lvl};
    return v << ch;
  endfunction

  function automatic bit rptDue(input int k);
    return (k >= 10) && (((k - 10) % 3) == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [11:0] want);
    checkOutput({tag, " hi"}, obs, want);
    checkOutput({tag, " lo"}, obs_al, want);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] raw);
    btn_raw = raw;
  endtask

  // Press ch0 (raw sampled at edge 0, press at P = edge 6), hold until P+hold, then let go.
  task automatic holdTest(input string name, input int hold, input int en_mode);
    logic [11:0] e;
    repeat_en = (en_mode == 1) ? 2'b01 : 2'b00;
    applyStimulus(2'b01);
    for (int c = 0; c < 6; c++) begin
      stepClock();
      checkBoth($sformatf("%s dbnc%0d", name, c), 12'h000);
    end
    for (int k = 0; k <= hold + 8; k++) begin
      stepClock();
      if (k == 0)              e = ev(0, 1, 1, 0, 0, 0, 0);
      else if (k < hold + 7)   e = ev(0, 1, 0, 0, (k == 20), 0, rptDue(k) && repeat_en[0]);
      else if (k == hold + 7)  e = ev(0, 0, 0, 1, 0, (hold + 6 >= 20), 0);
      else                     e = 12'h000;
      checkBoth($sformatf("%s P+%0d", name, k), e);
      if (k == hold) applyStimulus(2'b00);
      if (en_mode == 2 && k == 14) repeat_en = 2'b01;
    end
  endtask

  initial begin
    resetn    = 1'b0;
    repeat_en = 2'b00;
    applyStimulus(2'b00);
    for (int c = 0; c < 3; c++) begin
      stepClock();
      checkBoth($sformatf("reset%0d", c), 12'h000);
    end
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) stepClock();

    holdTest("short", 12, 0);
    holdTest("longrpt", 25, 1);

    // Bounce shorter than the debounce window must vanish without events.
    applyStimulus(2'b01);
    for (int c = 0; c < 3; c++) begin
      stepClock();
      checkBoth($sformatf("bounce hi%0d", c), 12'h000);
    end
    applyStimulus(2'b00);
    for (int c = 0; c < 10; c++) begin
      stepClock();
      checkBoth($sformatf("bounce lo%0d", c), 12'h000);
    end

    holdTest("norpt", 25, 0);
    holdTest("phase", 25, 2);

    // Channel 1 alone.
    repeat_en = 2'b00;
    applyStimulus(2'b10);
    for (int c = 0; c < 6; c++) begin
      stepClock();
      checkBoth($sformatf("ch1 dbnc%0d", c), 12'h000);
    end
    stepClock(); checkBoth("ch1 press", ev(1, 1, 1, 0, 0, 0, 0));
    stepClock(); checkBoth("ch1 held", ev(1, 1, 0, 0, 0, 0, 0));
    applyStimulus(2'b00);
    for (int c = 1; c <= 6; c++) begin
      stepClock();
      checkBoth($sformatf("ch1 drop%0d", c), ev(1, 1, 0, 0, 0, 0, 0));
    end
    stepClock(); checkBoth("ch1 release", ev(1, 0, 0, 1, 0, 0, 0));
    stepClock(); checkBoth("ch1 idle", 12'h000);

    // Reset in the middle of a hold, then a fresh debounce of the still-held input.
    applyStimulus(2'b01);
    for (int c = 0; c < 6; c++) stepClock();
    stepClock(); checkBoth("rst press", ev(0, 1, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 14; k++) begin
      stepClock();
      checkBoth($sformatf("rst hold%0d", k), ev(0, 1, 0, 0, 0, 0, 0));
    end
    resetn = 1'b0;
    stepClock(); checkBoth("rst mid", 12'h000);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stepClock();
      checkBoth($sformatf("rst redbnc%0d", c), 12'h000);
    end
    stepClock(); checkBoth("rst repress", ev(0, 1, 1, 0, 0, 0, 0));
    stepClock(); checkBoth("rst held", ev(0, 1, 0, 0, 0, 0, 0));
    applyStimulus(2'b00);
    for (int c = 1; c <= 6; c++) begin
      stepClock();
      checkBoth($sformatf("rst drop%0d", c), ev(0, 1, 0, 0, 0, 0, 0));
    end
    stepClock(); checkBoth("rst release", ev(0, 0, 0, 1, 0, 0, 0));
    stepClock(); checkBoth("rst idle", 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/button_event_unit.md
Name: button_event_unit

Overview:
Parametrised N-channel push-button front end that replaces per-button debouncers and ad-hoc edge/long-press logic in IO management. Each channel synchronises, debounces and classifies its raw input. It emits one-cycle event pulses: press, release, long press, long release and auto-repeat. Consumers include CPU single-step control, the debug-mode toggle and soft reset.

Parameters:
N_BTN, 5, number of independent button channels
DBNC_MAX, 20'hFFFFF, saturation value of the per-channel integrating debounce counter
LONG_CNT, 32'h0100_0000, cycles held after press before long_press fires
REPEAT_DELAY, 32'h0080_0000, cycles held after press before the first repeat pulse
REPEAT_PERIOD, 32'h0010_0000, cycles between subsequent repeat pulses (must be >= 1)
ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted before synchronisation

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
btn_raw  in  N_BTN  raw asynchronous button inputs
repeat_en  in  N_BTN  per-channel auto-repeat enable
level  out  N_BTN  debounced button state
press  out  N_BTN  1-cycle pulse on debounced rising edge
release  out  N_BTN  1-cycle pulse on debounced falling edge
long_press  out  N_BTN  1-cycle pulse when hold time reaches LONG_CNT
long_release  out  N_BTN  1-cycle pulse with release, only if long_press already fired during this hold
repeat  out  N_BTN  1-cycle auto-repeat pulses

Behaviour:
- Channels are fully independent. All counter widths are $clog2(param+1); every counter saturates and never wraps.
- Reset (resetn=0 at a clk edge): sync flops, debounce/hold/repeat counters, long flag, level and all pulse outputs go to 0.
  - Reset mid-hold discards the hold; no release is emitted.
  - After reset a held button must re-debounce and produces a fresh press.
- Synchroniser: two flops on (btn_raw ^ ACTIVE_LOW); s = second flop.
- Debounce, per cycle:
  - s=1 and cnt==DBNC_MAX: level<=1.
  - s=1 and cnt<DBNC_MAX: cnt++.
  - s=0 and cnt==0: level<=0.
  - s=0 and cnt>0: cnt--.
- Debounce latency: raw high sampled at edge 0 on a settled-low channel drives level and press high after edge DBNC_MAX+2. Release is symmetric.
- press/release are registered: asserted in the same cycle level first shows the new value, for exactly one cycle.
- Hold counter:
  - Cleared at the press edge.
  - Increments each cycle while level=1; saturates at LONG_CNT.
  - long_press pulses on the edge hold becomes LONG_CNT (LONG_CNT cycles after press) and sets long flag.
- Release edge:
  - long_release = long flag.
  - Long flag and hold counter then clear.
- Auto-repeat:
  - First repeat pulse when hold == REPEAT_DELAY.
  - Further pulses every REPEAT_PERIOD cycles while level=1, independent of LONG_CNT saturation via a separate period counter.
  - The schedule always runs internally; repeat is gated by repeat_en in the same cycle, so toggling repeat_en never shifts the phase.
  - No repeat in the press or release cycle.
- Simultaneous events:
  - long_press and repeat may pulse in the same cycle.
  - Press on one channel never affects another.
- A glitch shorter than DBNC_MAX net samples produces no events.

Test Plan (DBNC_MAX=4, LONG_CNT=20, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=2):
1. Raw ch0 high at edge 0, held -> level[0] and press[0] rise after edge 6; press[0] high exactly 1 cycle; ch1 outputs stay 0.
2. Bounce: ch0 raw 1 for 3 cycles, then 0 for 10 -> no press, level stays 0, debounce counter returns to 0.
3. Press at edge P, repeat_en=1, held 25 cycles:
   - repeat at P+10, P+13, P+16, P+19, P+22, P+25.
   - long_press at P+20 coincides with no repeat.
   - raw low -> release and long_release together, 1 cycle.
4. Press, hold 12 cycles, release -> release=1 and long_release=0; no long_press.
5. repeat_en=0 throughout a 25-cycle hold -> no repeat pulses. Raise repeat_en at P+14 -> next repeat at P+16 (phase preserved).
6. resetn=0 for one edge at P+15 while held -> all outputs 0, no release pulse. Held input re-presses at DBNC_MAX+2 edges after reset release, and ACTIVE_LOW=1 instance mirrors polarity.
